// File: rtl/sm_adc_pkg.sv
// Shared types and frame layout for the ADC128S022-style scan controller.
package sm_adc_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    localparam int ADC_BITS       = 12;
    localparam int NUM_CH         = 8;
    localparam int FRAME_BITS     = 16;
    localparam int ADDR_FIRST_BIT = 2;
    localparam int ADDR_LAST_BIT  = 4;
    localparam int DATA_START_BIT = 4;

    // DIN frame is 0,0,A2,A1,A0 followed by zeros.
    function automatic logic frame_bit(input logic [3:0] b, input logic [2:0] ch);
        logic bit_v;
        bit_v = 1'b0;
        if (b == 4'(ADDR_FIRST_BIT))
            bit_v = ch[2];
        else if (b == 4'(ADDR_FIRST_BIT + 1))
            bit_v = ch[1];
        else if (b == 4'(ADDR_LAST_BIT))
            bit_v = ch[0];
        return bit_v;
    endfunction

endpackage

// File: rtl/sm_adc_rr_pick.sv
// Round-robin channel picker: next set bit of mask strictly after ptr, wrapping 7->0.
module sm_adc_rr_pick
    import sm_adc_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [2:0]        ptr,
    output logic [2:0]        pick
);

    logic [2:0] idx;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        pick = ptr;
        idx  = ptr;
        // Scan from farthest to nearest so the nearest hit wins; i = 8 wraps to ptr itself.
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = ptr + 3'(i);
            if (mask[idx])
                pick = idx;
        end
    end

endmodule

// File: rtl/sm_adc_scheduler.sv
// Round-robin ADC128S022-style frame sequencer driven from clk_50M.
// Optional build macro SM_ADC_AVG_EN: emit per-channel averages of 4 samples instead of raw samples.
module sm_adc_scheduler
    import sm_adc_pkg::*;
#(
    parameter int SCLK_HALF    = 8,
    parameter int SETUP_CYCLES = 8,
    parameter int GAP_CYCLES   = 16
) (
    input  logic                clk_50M,
    input  logic                rst_n,
    input  logic                en,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                adc_dout,
    output logic                adc_cs_n,
    output logic                adc_sck,
    output logic                adc_din,
    output logic [ADC_BITS-1:0] data_out,
    output logic [2:0]          data_ch,
    output logic                data_valid,
    output logic                busy
);

    localparam logic [15:0] HALF_LAST  = 16'(SCLK_HALF - 1);
    localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

    state_t              state;
    logic [15:0]         cnt;
    logic [3:0]          bit_idx;
    logic [2:0]          cur_ch;
    logic [2:0]          prev_ch;
    logic [2:0]          rr_ptr;
    logic [2:0]          pick;
    logic                prev_valid;
    logic [ADC_BITS-1:0] shreg;
    logic                scan_go;
    logic                gap_done;
    logic                launch;

    sm_adc_rr_pick u_pick (
        .mask (ch_en),
        .ptr  (rr_ptr),
        .pick (pick)
    );

    assign scan_go  = en && (ch_en != '0);
    assign gap_done = (state == GAP) && (cnt == GAP_LAST);
    assign launch   = scan_go && ((state == IDLE) || gap_done);

`ifdef SM_ADC_AVG_EN
    logic [ADC_BITS+1:0] acc [NUM_CH];
    logic [1:0]          acc_cnt [NUM_CH];
    logic [ADC_BITS+1:0] acc_sum;

    assign acc_sum = acc[prev_ch] + {2'b00, shreg};
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            cur_ch     <= '0;
            prev_ch    <= '0;
            rr_ptr     <= 3'd7;
            prev_valid <= 1'b0;
            shreg      <= '0;
            adc_cs_n   <= 1'b1;
            adc_sck    <= 1'b1;
            adc_din    <= 1'b0;
            data_out   <= '0;
            data_ch    <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
`ifdef SM_ADC_AVG_EN
            // NOTE: the accumulator array is reset explicitly; it is small register state, not RAM.
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i]     <= '0;
                acc_cnt[i] <= '0;
            end
`endif
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    prev_valid <= 1'b0;
`ifdef SM_ADC_AVG_EN
                    for (int i = 0; i < NUM_CH; i++) begin
                        acc[i]     <= '0;
                        acc_cnt[i] <= '0;
                    end
`endif
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        state   <= SHIFT;
                        cnt     <= '0;
                        bit_idx <= '0;
                        adc_sck <= 1'b0;
                        adc_din <= frame_bit(4'd0, cur_ch);
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                SHIFT: begin
                    // First cycle of the high half-period is the rising-edge sample point.
                    if (adc_sck && (cnt == '0) && (bit_idx >= 4'(DATA_START_BIT)))
                        shreg <= {shreg[ADC_BITS-2:0], adc_dout};
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!adc_sck) begin
                            adc_sck <= 1'b1;
                        end else if (bit_idx == 4'(FRAME_BITS - 1)) begin
                            state      <= GAP;
                            adc_cs_n   <= 1'b1;
                            adc_din    <= 1'b0;
                            prev_valid <= 1'b1;
                            prev_ch    <= cur_ch;
                            // This frame's data belongs to the channel addressed one frame earlier.
                            if (prev_valid) begin
`ifdef SM_ADC_AVG_EN
                                if (acc_cnt[prev_ch] == 2'd3) begin
                                    data_valid       <= 1'b1;
                                    data_out         <= acc_sum[ADC_BITS+1:2];
                                    data_ch          <= prev_ch;
                                    acc[prev_ch]     <= '0;
                                    acc_cnt[prev_ch] <= '0;
                                end else begin
                                    acc[prev_ch]     <= acc_sum;
                                    acc_cnt[prev_ch] <= acc_cnt[prev_ch] + 2'd1;
                                end
`else
                                data_valid <= 1'b1;
                                data_out   <= shreg;
                                data_ch    <= prev_ch;
`endif
                            end
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            adc_sck <= 1'b0;
                            adc_din <= frame_bit(bit_idx + 4'd1, cur_ch);
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        if (!launch) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Frame start is shared by IDLE exit and back-to-back frames; ch_en is sampled only here.
            if (launch) begin
                state    <= SETUP;
                cnt      <= '0;
                adc_cs_n <= 1'b0;
                busy     <= 1'b1;
                cur_ch   <= pick;
                rr_ptr   <= pick;
            end
        end
    end

endmodule

// File: tb/tb_sm_adc_scheduler.sv
// Scoreboard bench for sm_adc_scheduler with a behavioural ADC128S022-style slave model.
module tb_sm_adc_scheduler;

    logic        clk_50M = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  ch_en = 8'h00;
    logic        adc_dout = 1'b0;
    logic        adc_cs_n;
    logic        adc_sck;
    logic        adc_din;
    logic [11:0] data_out;
    logic [2:0]  data_ch;
    logic        data_valid;
    logic        busy;

    sm_adc_scheduler dut (
        .clk_50M    (clk_50M),
        .rst_n      (rst_n),
        .en         (en),
        .ch_en      (ch_en),
        .adc_dout   (adc_dout),
        .adc_cs_n   (adc_cs_n),
        .adc_sck    (adc_sck),
        .adc_din    (adc_din),
        .data_out   (data_out),
        .data_ch    (data_ch),
        .data_valid (data_valid),
        .busy       (busy)
    );

    always #10 clk_50M = ~clk_50M;

    int unsigned cyc = 0;
    always @(posedge clk_50M) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] data;
        int unsigned at;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [11:0] adc_val [8];
    logic [11:0] samp_q[$];
    logic [2:0]  addr_log[$];
    int          last_bits = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ADC slave: shifts 4 zeros then D11..D0 after each SCK fall, captures A2..A0 on SCK rise,
    // and returns the conversion for the address captured in the previous frame.
    logic        sck_q = 1'b1;
    logic        in_frame = 1'b0;
    int          m_bit = 0;
    logic [2:0]  m_addr = 3'd0;
    logic [2:0]  m_prev = 3'd0;
    logic [11:0] m_word = 12'd0;

    always @(negedge clk_50M) begin
        if (adc_cs_n) begin
            if (in_frame) begin
                addr_log.push_back(m_addr);
                last_bits = m_bit;
                m_prev    = m_addr;
                in_frame  = 1'b0;
            end
            sck_q    = 1'b1;
            adc_dout = 1'b0;
        end else begin
            if (!in_frame) begin
                in_frame = 1'b1;
                m_bit    = 0;
                m_addr   = 3'd0;
                if (samp_q.size() > 0) m_word = samp_q.pop_front();
                else                   m_word = adc_val[m_prev];
            end
            if (sck_q && !adc_sck)
                adc_dout = (m_bit >= 4 && m_bit < 16) ? m_word[15 - m_bit] : 1'b0;
            if (!sck_q && adc_sck) begin
                if (m_bit >= 2 && m_bit <= 4) m_addr = {m_addr[1:0], adc_din};
                m_bit++;
            end
            sck_q = adc_sck;
        end
    end

    // Monitor: every strobe must match the oldest expected result, including its cycle.
    always @(negedge clk_50M) begin
        if (rst_n && data_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got ch %0d data %0h at cycle %0d, required no strobe",
                         data_ch, data_out, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("valid_ch", 32'(data_ch), 32'(mon_e.ch));
                check("valid_data", 32'(data_out), 32'(mon_e.data));
                check("valid_cycle", cyc, mon_e.at);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_50M);
    endtask

    task automatic wait_cyc(input int unsigned c);
        while (cyc < c) tick(1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        ch_en = 8'h00;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        addr_log.delete();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cs_n"}, 32'(adc_cs_n), 32'd1);
        check({tag, "_sck"}, 32'(adc_sck), 32'd1);
        check({tag, "_din"}, 32'(adc_din), 32'd0);
        check({tag, "_data_out"}, 32'(data_out), 32'd0);
        check({tag, "_data_ch"}, 32'(data_ch), 32'd0);
        check({tag, "_valid"}, 32'(data_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Raises en with the given mask and returns the cycle index of the first cs_n-low cycle.
    task automatic start_scan(input logic [7:0] m, output int unsigned t0);
        int unsigned e_cyc;
        ch_en = m;
        en    = 1'b1;
        e_cyc = cyc;
        for (int i = 0; i < 8 && adc_cs_n; i++) tick(1);
        check("cs_fall_latency", cyc, e_cyc + 1);
        t0 = cyc;
    endtask

    int unsigned t0;

    initial begin
        for (int i = 0; i < 8; i++) adc_val[i] = 12'(16 * i + 1);

        // Reset held, then released with en low: idle forever.
        rst_n = 1'b0;
        tick(4);
        check_idle("in_reset");
        rst_n = 1'b1;
        tick(1);
        check_idle("released");
        tick(50);
        check_idle("idle_50");

`ifdef SM_ADC_AVG_EN
        // Channel 3 only, four samples 100..103 -> one averaged result of 101.
        do_reset();
        samp_q.delete();
        samp_q.push_back(12'd0);
        samp_q.push_back(12'd100);
        samp_q.push_back(12'd101);
        samp_q.push_back(12'd102);
        samp_q.push_back(12'd103);
        start_scan(8'h08, t0);
        sb.push_back('{3'd3, 12'd101, t0 + 280 * 4 + 264});
        wait_cyc(t0 + 280 * 5 + 10);
        check("avg_sb_drained", sb.size(), 0);
`else
        // Single channel 0 returning 0xABC: first result at 544, then every 280 cycles.
        do_reset();
        adc_val[0] = 12'hABC;
        start_scan(8'h01, t0);
        check("busy_running", 32'(busy), 32'd1);
        for (int k = 0; k < 3; k++) sb.push_back('{3'd0, 12'hABC, t0 + 544 + 280 * k});
        wait_cyc(t0 + 280 * 4 + 10);
        check("ch0_sb_drained", sb.size(), 0);
        check("ch0_addr_count", 32'(addr_log.size() >= 4), 32'd1);
        for (int k = 0; k < 4; k++) check("ch0_addr", 32'(addr_log[k]), 32'd0);

        // Channels 0 and 2: addresses alternate 0,2,0,2 and results lag by one frame.
        do_reset();
        adc_val[0] = 12'h123;
        adc_val[2] = 12'h456;
        start_scan(8'h05, t0);
        sb.push_back('{3'd0, 12'h123, t0 + 544});
        sb.push_back('{3'd2, 12'h456, t0 + 824});
        sb.push_back('{3'd0, 12'h123, t0 + 1104});
        wait_cyc(t0 + 280 * 4 + 10);
        check("ch02_sb_drained", sb.size(), 0);
        check("ch02_addr_count", 32'(addr_log.size() >= 4), 32'd1);
        check("ch02_addr0", 32'(addr_log[0]), 32'd0);
        check("ch02_addr1", 32'(addr_log[1]), 32'd2);
        check("ch02_addr2", 32'(addr_log[2]), 32'd0);
        check("ch02_addr3", 32'(addr_log[3]), 32'd2);
`endif

        // Mask drops at cycle 100: frame completes, IDLE and busy low at cycle 280.
        do_reset();
        start_scan(8'h01, t0);
        wait_cyc(t0 + 100);
        ch_en = 8'h00;
        wait_cyc(t0 + 279);
        check("drop_busy_279", 32'(busy), 32'd1);
        wait_cyc(t0 + 280);
        check("drop_busy_280", 32'(busy), 32'd0);
        check("drop_cs_280", 32'(adc_cs_n), 32'd1);
        wait_cyc(t0 + 300);
        check("drop_cs_300", 32'(adc_cs_n), 32'd1);
        check("drop_frames", addr_log.size(), 1);
        check("drop_full_frame", 32'(last_bits), 32'd16);

        // Reset at cycle 150 of a frame: outputs back to reset values, restart addresses channel 0.
        do_reset();
        start_scan(8'h03, t0);
        wait_cyc(t0 + 150);
        rst_n = 1'b0;
        tick(1);
        check("rst_cs_n", 32'(adc_cs_n), 32'd1);
        check("rst_sck", 32'(adc_sck), 32'd1);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick(2);
        addr_log.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 8 && adc_cs_n; i++) tick(1);
        check("restart_cs_low", 32'(adc_cs_n), 32'd0);
        t0 = cyc;
        wait_cyc(t0 + 100);
        en = 1'b0;
        wait_cyc(t0 + 300);
        check("restart_frames", addr_log.size(), 1);
        check("restart_addr", 32'(addr_log[0]), 32'd0);
        check("restart_idle", 32'(busy), 32'd0);
        check("final_sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish, required completion within bound");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sm_adc_scheduler.md
# sm_adc_scheduler

Controller that sequences the on-board 8-channel serial ADC (ADC128S022-style, 16-clock frames) directly from `clk_50M`. It generates the 3.125 MHz ADC serial clock internally, scans enabled channels round-robin, and presents each conversion as a tagged, single-cycle-valid result. It sits between the frequency-scaling/clock domain and the sensor-processing logic (soil moisture, line sensors), replacing free-running ADC clock use.

## Interface
- `SCLK_HALF`, 8: `clk_50M` cycles per `adc_sck` half-period (8 gives 3.125 MHz).
- `SETUP_CYCLES`, 8: cycles `adc_cs_n` is low before the first `adc_sck` fall.
- `GAP_CYCLES`, 16: cycles `adc_cs_n` is high between frames.
- `clk_50M`  in  1  system clock, 50 MHz, all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `en`  in  1  scan enable.
- `ch_en`  in  8  channel enable mask, bit i = channel i.
- `adc_dout`  in  1  serial data from ADC.
- `adc_cs_n`  out  1  ADC chip select, active low.
- `adc_sck`  out  1  ADC serial clock, idles high.
- `adc_din`  out  1  serial address to ADC.
- `data_out`  out  12  conversion result.
- `data_ch`  out  3  channel `data_out` belongs to.
- `data_valid`  out  1  one-cycle strobe, `data_out`/`data_ch` valid.
- `busy`  out  1  high whenever not in IDLE.

## Operation
- Reset values: `adc_cs_n`=1, `adc_sck`=1, `adc_din`=0, `data_out`=0, `data_ch`=0, `data_valid`=0, `busy`=0. Round-robin pointer = 7, so channel 0 is first. `prev_valid`=0.
- States: IDLE → SETUP → SHIFT → GAP → (SETUP or IDLE).
- IDLE: leave when `en`=1 and `ch_en`≠0. `prev_valid` is cleared.
- Channel selection happens on entry to SETUP. The block picks the next set bit of `ch_en` strictly after the pointer, wrapping 7→0. If only one bit is set, it reselects that channel. `ch_en` is sampled only at this point.
- SETUP: `adc_cs_n`=0, `adc_sck`=1.
- SHIFT: 16 bit periods b=0..15.
  - In each period, `adc_sck` is low for `SCLK_HALF` cycles, then high for `SCLK_HALF` cycles.
  - `adc_din` updates on the `adc_sck` falling transition. Frame bits are 0,0,A2,A1,A0,0…0.
  - `adc_dout` is sampled on the cycle `adc_sck` goes 0→1. Bits b=4..15 form D11..D0, MSB first.
- GAP: `adc_cs_n`=1, `adc_sck`=1.
  - On the first GAP cycle, if `prev_valid`=1, pulse `data_valid`. `data_ch` is the channel addressed in the previous frame, because the ADC returns the conversion for the previously addressed channel.
  - The block then sets `prev_valid`=1 and latches the current address as the previous address.
  - At the end of GAP: go to SETUP if `en`=1 and `ch_en`≠0, else go to IDLE.
- `en` or `ch_en` dropping mid-frame never truncates a frame; the current frame always completes.
- The first frame after IDLE produces no `data_valid`.

## Timing
- Cycle 0 is the first cycle of `adc_cs_n` low. SHIFT spans cycles 8–263, GAP spans 264–279, and the next `adc_cs_n` fall is at cycle 280.
- Frame period: 280 cycles. Rising-edge sample for bit b occurs at cycle 16+16b; the last sample is at cycle 256.
- `data_valid` occurs at cycle 264 of each frame, starting with the second frame. The first result after leaving IDLE arrives at cycle 544.
- Reset mid-frame: on the next edge, all outputs return to their reset values and any partial result is dropped.

## Configuration
- `SM_ADC_AVG_EN` defined: each channel has a 14-bit accumulator and 2-bit count.
  - `data_valid` fires only on every 4th sample per channel, with `data_out` = sum>>2 (truncated). The accumulator and count then clear.
  - Accumulators clear on reset and on IDLE entry.
- Not defined: every sample after the first frame is emitted raw, and no accumulators exist.

## Structure
- Shared package `sm_adc_pkg`: state enum, frame bit positions (address bits 2–4, data start bit 4), `ADC_BITS=12`, `NUM_CH=8`.
- One sub-module, `sm_adc_rr_pick`: combinational next-set-bit search over the 8-bit mask from the pointer, with wrap.

## Test plan
- Reset held, then released with `en`=0 → all outputs hold reset values and `busy`=0 indefinitely.
- `ch_en`=0x01 with an ADC model returning 0xABC → `data_ch`=0, `data_out`=0xABC, first `data_valid` at cycle 544, then every 280 cycles. `adc_din` address bits are 000.
- `ch_en`=0x05 → address sequence 0,2,0,2 and result channels 0,2,0 lag by one frame. No valid is emitted for the first frame.
- `ch_en`→0 at cycle 100 of a frame → the frame completes, then the block goes to IDLE at cycle 280. `busy` falls there.
- `rst_n` low at cycle 150 → on the next cycle `adc_cs_n`=1, `adc_sck`=1, and no `data_valid` follows. On restart, channel 0 is addressed first.
- With `SM_ADC_AVG_EN` on, channel 3 only, samples 100,101,102,103 → a single `data_valid` with `data_out`=101.
